// File: rtl/uart_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_bridge_if
// Description : Request handshake between the CPU io path (initiator) and
//               the UART bridge (responder): order/accepted/done plus the
//               request attributes and the returned receive word.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_bridge_if;
    logic        uart_order;
    logic        uart_write;
    logic [1:0]  uart_size;
    logic [31:0] uart_o_data;
    logic        uart_accepted;
    logic        uart_done;
    logic [31:0] uart_i_data;

    modport master (
        output uart_order, uart_write, uart_size, uart_o_data,
        input  uart_accepted, uart_done, uart_i_data
    );

    modport slave (
        input  uart_order, uart_write, uart_size, uart_o_data,
        output uart_accepted, uart_done, uart_i_data
    );
endinterface
`default_nettype wire

// File: rtl/uart_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_bridge
// Description : Responder for 1/2/4-byte UART send/receive requests. Send
//               requests stream bytes little-endian to the serial transmitter;
//               receive requests assemble bytes popped from an RX FIFO that
//               buffers every incoming byte regardless of request state.
//               Optional feature macro: UART_BRIDGE_OVF_EN (sticky drop flag).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bridge #(
    parameter int RX_DEPTH = 16,
    parameter int RX_AW    = 4
) (
    input  wire logic       clk,
    input  wire logic       rstn,
    uart_bridge_if.slave    bus,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  wire logic       tx_ready,
    input  wire logic [7:0] rx_data,
    input  wire logic       rx_valid,
    output logic            rx_overflow
);

    typedef enum logic [1:0] {
        c_st_idle = 2'd0,
        c_st_tx   = 2'd1,
        c_st_rx   = 2'd2,
        c_st_done = 2'd3
    } state_t;

    localparam logic [RX_AW:0] c_ptr_one = {{RX_AW{1'b0}}, 1'b1};

    state_t         r_state;
    logic [1:0]     r_last;      // index of the final byte (n-1)
    logic [1:0]     r_k;         // current byte index
    logic [31:0]    r_data;
    logic           r_accepted;
    logic           r_done;
    logic [31:0]    r_i_data;

    logic [7:0]     r_mem [RX_DEPTH];
    logic [RX_AW:0] r_wptr;
    logic [RX_AW:0] r_rptr;

    logic           w_empty;
    logic           w_full;
    logic           w_pop;
    logic           w_push;
    logic [7:0]     w_rd_byte;
    logic [1:0]     w_last_idx;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[RX_AW] != r_rptr[RX_AW]) &&
                       (r_wptr[RX_AW-1:0] == r_rptr[RX_AW-1:0]);
    assign w_pop     = (r_state == c_st_rx) && !w_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
    assign w_push    = rx_valid && (!w_full || w_pop);
    assign w_rd_byte = r_mem[r_rptr[RX_AW-1:0]];

    assign w_last_idx = (bus.uart_size == 2'b00) ? 2'd0 :
                        (bus.uart_size == 2'b01) ? 2'd1 : 2'd3;

    assign tx_valid          = (r_state == c_st_tx);
    assign tx_data           = r_data[{r_k, 3'b000} +: 8];
    assign bus.uart_accepted = r_accepted;
    assign bus.uart_done     = r_done;
    assign bus.uart_i_data   = r_i_data;

    // Request sequencing: latch on order, stream bytes, pulse done.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= c_st_idle;
            r_last     <= 2'd0;
            r_k        <= 2'd0;
            r_data     <= 32'd0;
            r_accepted <= 1'b0;
            r_done     <= 1'b0;
            r_i_data   <= 32'd0;
        end else begin
            r_accepted <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (bus.uart_order) begin
                        r_data     <= bus.uart_o_data;
                        r_last     <= w_last_idx;
                        r_k        <= 2'd0;
                        r_accepted <= 1'b1;
                        if (bus.uart_write) begin
                            r_state <= c_st_tx;
                        end else begin
                            // Upper bytes must read as zero for short receives.
                            r_i_data <= 32'd0;
                            r_state  <= c_st_rx;
                        end
                    end
                end
                c_st_tx: begin
                    if (tx_ready) begin
                        r_k <= r_k + 2'd1;
                        if (r_k == r_last) begin
                            r_state <= c_st_done;
                            r_done  <= 1'b1;
                        end
                    end
                end
                c_st_rx: begin
                    if (w_pop) begin
                        r_i_data[{r_k, 3'b000} +: 8] <= w_rd_byte;
                        r_k <= r_k + 2'd1;
                        if (r_k == r_last) begin
                            r_state <= c_st_done;
                            r_done  <= 1'b1;
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // RX FIFO pointer update.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
        end
    end

    // RX FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[RX_AW-1:0]] <= rx_data;
        end
    end

`ifdef UART_BRIDGE_OVF_EN
    logic r_ovf;

    // Sticky flag for a byte lost to a full FIFO; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
        end else if (rx_valid && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end
    end

    assign rx_overflow = r_ovf;
`else
    assign rx_overflow = 1'b0;
`endif

endmodule
`default_nettype wire
